// File: rtl/rom_loader_pkg.sv
// Shared types for the ROM download path: loader states, byte lanes and the
// packed memory word that travels through the write FIFO.
package rom_loader_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;
  localparam logic [1:0] BE_FULL = 2'b11;

  // Widest word address carried in a FIFO entry; the top truncates to MEM_AW.
  localparam int ADDR_MAX_W = 24;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr;
    logic [15:0]           data;
    logic [1:0]            be;
  } word_t;

  // Drop one byte into the selected lane and raise that lane's enable.
  function automatic word_t merge_byte(input word_t w, input logic lane, input logic [7:0] b);
    word_t r;
    r = w;
    if (lane) begin
      r.data[8*LANE_HI +: 8] = b;
      r.be[LANE_HI]          = 1'b1;
    end else begin
      r.data[8*LANE_LO +: 8] = b;
      r.be[LANE_LO]          = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with registered occupancy count. A pop in the same cycle
// as a push into a full FIFO frees the slot, so the push is kept.
module word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rom_download_ctrl.sv
// Packs the ioctl byte stream into 16-bit SDRAM writes with byte enables,
// queues them and hands them to memory over a req/ack handshake.
module rom_download_ctrl
  import rom_loader_pkg::*;
#(
  parameter logic [7:0]        ROM_INDEX  = 8'h00,
  parameter logic [24:0]       ROM_BYTES  = 25'h0400000,
  parameter int                MEM_AW     = 23,
  parameter logic [MEM_AW-1:0] BASE_WORD  = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state, state_n;
  logic            dl_q, stg_vld, stg_vld_n, ovf_n, done_raw;
  word_t           stg, stg_n, push_word, head, fresh, merged;
  logic            push, pop, full, empty;
  logic [CW-1:0]   count;
  logic            dl_rise, dl_fall, idx_hit, accept;
  logic [MEM_AW-1:0] w_addr;
  logic            unused_addr;

  assign idx_hit = (ioctl_index == ROM_INDEX);
  assign dl_rise = ioctl_download && !dl_q;
  assign dl_fall = !ioctl_download && dl_q;
  assign accept  = (state == LOAD) && ioctl_wr && ioctl_download && idx_hit
                   && (ioctl_addr < ROM_BYTES);
  assign w_addr  = BASE_WORD + ioctl_addr[MEM_AW:1];
  assign pop     = mem_ack && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      dl_q     <= 1'b0;
      stg      <= '0;
      stg_vld  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      dl_q     <= ioctl_download;
      stg      <= stg_n;
      stg_vld  <= stg_vld_n;
      overflow <= ovf_n;
    end
  end

  always_comb begin
    state_n   = state;
    stg_n     = stg;
    stg_vld_n = stg_vld;
    push      = 1'b0;
    push_word = stg;
    ovf_n     = overflow;
    done_raw  = 1'b0;
    fresh      = '0;
    fresh.addr = ADDR_MAX_W'(w_addr);
    fresh      = merge_byte(fresh, ioctl_addr[0], ioctl_dout);
    merged     = merge_byte(stg, ioctl_addr[0], ioctl_dout);
    unique case (state)
      IDLE: begin
        if (dl_rise && idx_hit) begin
          state_n = LOAD;
          ovf_n   = 1'b0;
        end
      end
      LOAD: begin
        if (dl_fall) begin
          // Flush whatever partial word is still staged.
          state_n   = DRAIN;
          push      = stg_vld;
          stg_vld_n = 1'b0;
        end else if (accept) begin
          if (!stg_vld) begin
            stg_n     = fresh;
            stg_vld_n = 1'b1;
          end else if (stg.addr == fresh.addr) begin
            if (merged.be == BE_FULL) begin
              push      = 1'b1;
              push_word = merged;
              stg_vld_n = 1'b0;
            end else begin
              stg_n = merged;
            end
          end else begin
            push  = 1'b1;
            stg_n = fresh;
          end
        end
      end
      DRAIN: begin
        if (empty) begin
          state_n  = IDLE;
          done_raw = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (push && full && !pop) ovf_n = 1'b1;
  end

  word_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign busy       = (state != IDLE);
  assign done       = done_raw && !reset;
  // Threshold one below depth leaves room for the strobe already in flight.
  assign ioctl_wait = busy && (count >= CW'(FIFO_DEPTH - 1));
  assign mem_req    = !empty;
  assign mem_addr   = head.addr[MEM_AW-1:0];
  assign mem_data   = head.data;
  assign mem_be     = head.be;
  assign unused_addr = &{1'b0, head.addr};

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Randomized and directed bench for rom_download_ctrl against a queue-based
// model of the byte packer, write FIFO and loader phases.
module tb_rom_download_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [24:0] RB    = 25'h0400000;

  logic        clock = 1'b0;
  logic        reset, ioctl_download, ioctl_wr, mem_ack;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        ioctl_wait, mem_req, busy, done, overflow;
  logic [22:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_be;

  always #10 clock = ~clock;

  rom_download_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_be         (mem_be),
    .mem_ack        (mem_ack),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  typedef struct {
    int unsigned addr;
    logic [15:0] data;
    logic [1:0]  be;
  } mw_t;

  mw_t q[$];
  mw_t wlog[$];
  mw_t m_st;
  bit  m_load, m_drain, m_ovf, m_stv, m_dlp, saw_wait;
  int  n_chk, n_fail, done_cnt, ack_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  task automatic m_push(input mw_t w);
    if (q.size() < DEPTH) q.push_back(w);
    else m_ovf = 1'b1;
  endtask

  // Advance the model by one clock using the inputs seen at the edge.
  task automatic model_step();
    int unsigned w;
    bit empty_pre;
    if (reset) begin
      q.delete();
      m_load = 0; m_drain = 0; m_ovf = 0; m_stv = 0; m_dlp = 0;
      return;
    end
    empty_pre = (q.size() == 0);
    if (mem_ack && q.size() > 0) void'(q.pop_front());
    if (m_load) begin
      if (!ioctl_download && m_dlp) begin
        m_load = 0; m_drain = 1;
        if (m_stv) m_push(m_st);
        m_stv = 0;
      end else if (ioctl_wr && ioctl_download && ioctl_index == 8'h00 && ioctl_addr < RB) begin
        w = (32'(ioctl_addr) >> 1) & 32'h7FFFFF;
        if (m_stv && m_st.addr != w) begin
          m_push(m_st);
          m_stv = 0;
        end
        if (!m_stv) begin
          m_st.addr = w; m_st.data = 16'h0; m_st.be = 2'b00; m_stv = 1;
        end
        if (ioctl_addr[0]) begin m_st.data[15:8] = ioctl_dout; m_st.be[1] = 1'b1; end
        else               begin m_st.data[7:0]  = ioctl_dout; m_st.be[0] = 1'b1; end
        if (m_st.be == 2'b11) begin
          m_push(m_st);
          m_stv = 0;
        end
      end
    end else if (m_drain) begin
      if (empty_pre) m_drain = 0;
    end else if (ioctl_download && !m_dlp && ioctl_index == 8'h00) begin
      m_load = 1;
      m_ovf  = 0;
    end
    m_dlp = ioctl_download;
  endtask

  task automatic compare();
    logic [15:0] mk;
    bit b;
    b = m_load || m_drain;
    chk("mem_req", 32'(mem_req), 32'(q.size() != 0));
    if (q.size() != 0) begin
      mk = {{8{q[0].be[1]}}, {8{q[0].be[0]}}};
      chk("mem_addr", 32'(mem_addr), q[0].addr);
      chk("mem_be", 32'(mem_be), 32'(q[0].be));
      chk("mem_data", 32'(mem_data & mk), 32'(q[0].data & mk));
    end
    chk("busy", 32'(busy), 32'(b));
    chk("ioctl_wait", 32'(ioctl_wait), 32'(b && q.size() >= DEPTH - 1));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("done", 32'(done), 32'(m_drain && q.size() == 0 && !reset));
    if (done) done_cnt++;
    if (ioctl_wait) saw_wait = 1;
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
    case (ack_mode)
      0:       mem_ack = 1'b0;
      1:       mem_ack = mem_req;
      default: mem_ack = ($urandom_range(0, 2) != 0);
    endcase
    if (mem_ack && mem_req) wlog.push_back('{32'(mem_addr), mem_data, mem_be});
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d, input bit obey);
    int t = 0;
    while (obey && ioctl_wait && t < 200) begin cyc(); t++; end
    if (t >= 200) timeout("host_wait");
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    cyc();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    cyc(); cyc();
  endtask

  task automatic end_dl();
    int t = 0;
    ioctl_download = 1'b0;
    cyc();
    while (busy && t < 300) begin cyc(); t++; end
    if (busy) timeout("drain");
  endtask

  logic [15:0] t1d [4] = '{16'h2211, 16'h4433, 16'h6655, 16'h8877};

  initial begin
    logic [24:0] a;
    int n;
    reset = 1; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_index = '0; mem_ack = 0; ack_mode = 1;
    n_chk = 0; n_fail = 0; done_cnt = 0; saw_wait = 0;
    repeat (3) cyc();
    reset = 0;
    cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);

    // Sequential 8-byte download.
    wlog.delete(); done_cnt = 0;
    start_dl(8'h00);
    for (int i = 0; i < 8; i++) begin send(25'(i), 8'(8'h11 * (i + 1)), 1); cyc(); end
    end_dl();
    chk("t1_nwr", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("t1_addr", wlog[i].addr, i);
      chk("t1_data", 32'(wlog[i].data), 32'(t1d[i]));
      chk("t1_be", 32'(wlog[i].be), 3);
    end
    chk("t1_done", done_cnt, 1);
    chk("t1_busy", 32'(busy), 0);

    // Odd length: trailing partial word flushed at download end.
    wlog.delete();
    start_dl(8'h00);
    send(25'h0, 8'hAA, 1); cyc();
    send(25'h1, 8'hBB, 1); cyc();
    send(25'h2, 8'hCC, 1); cyc();
    end_dl();
    chk("t2_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t2_a0", wlog[0].addr, 0);
      chk("t2_d0", 32'(wlog[0].data), 32'h BBAA);
      chk("t2_b0", 32'(wlog[0].be), 3);
      chk("t2_a1", wlog[1].addr, 1);
      chk("t2_d1", 32'(wlog[1].data[7:0]), 32'h CC);
      chk("t2_b1", 32'(wlog[1].be), 1);
    end

    // Non-sequential addresses.
    wlog.delete();
    start_dl(8'h00);
    send(25'h10, 8'h55, 1); cyc();
    send(25'h21, 8'h66, 1); cyc();
    end_dl();
    chk("t3_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t3_a0", wlog[0].addr, 8);
      chk("t3_d0", 32'(wlog[0].data[7:0]), 32'h55);
      chk("t3_b0", 32'(wlog[0].be), 1);
      chk("t3_a1", wlog[1].addr, 32'h10);
      chk("t3_d1", 32'(wlog[1].data[15:8]), 32'h66);
      chk("t3_b1", 32'(wlog[1].be), 2);
    end

    // Stalled memory, host ignoring wait.
    start_dl(8'h00);
    ack_mode = 0; saw_wait = 0;
    for (int i = 0; i < 12; i++) send(25'(i), 8'(i), 0);
    chk("t4_wait", 32'(ioctl_wait), 1);
    chk("t4_saw_wait", 32'(saw_wait), 1);
    chk("t4_ovf", 32'(overflow), 1);
    ack_mode = 1;
    end_dl();
    chk("t4_ovf_sticky", 32'(overflow), 1);

    // Next start clears overflow; then reset with two words queued.
    start_dl(8'h00);
    chk("t4_ovf_clr", 32'(overflow), 0);
    ack_mode = 0;
    for (int i = 0; i < 4; i++) begin send(25'(i), 8'(i + 1), 1); cyc(); end
    chk("t5_req", 32'(mem_req), 1);
    done_cnt = 0;
    reset = 1; ioctl_download = 0;
    cyc();
    chk("t5_req_drop", 32'(mem_req), 0);
    chk("t5_busy", 32'(busy), 0);
    reset = 0;
    cyc(); cyc();
    chk("t5_done", done_cnt, 0);
    ack_mode = 1;

    // Foreign index is ignored.
    wlog.delete(); done_cnt = 0;
    start_dl(8'h01);
    for (int i = 0; i < 4; i++) begin send(25'(i), 8'(i), 1); cyc(); end
    end_dl();
    chk("t6_nwr", wlog.size(), 0);
    chk("t6_done", done_cnt, 0);
    chk("t6_busy", 32'(busy), 0);

    // Randomized downloads, random ack timing, boundary addresses.
    for (int r = 0; r < 40; r++) begin
      ack_mode = 2;
      start_dl(($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00);
      a = ($urandom_range(0, 9) == 0) ? RB - 25'($urandom_range(1, 4)) : 25'($urandom_range(0, 255));
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        send(a, 8'($urandom), $urandom_range(0, 9) != 0);
        repeat ($urandom_range(0, 2)) cyc();
        a = ($urandom_range(0, 4) == 0) ? 25'($urandom_range(0, 32'(RB) + 2)) : a + 25'd1;
      end
      end_dl();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
